// File: rtl/autobaud_detector.sv
// Autobaud detector: times five falling edges of a 0x55 sync character and reports clocks-per-bit.
// Optional interval-consistency check enabled by defining AUTOBAUD_CHECK_EN.
module autobaud_detector #(
  parameter int CNT_WIDTH   = 20,
  parameter int IDLE_CYCLES = 64,
  parameter int MIN_PERIOD  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx,
  output logic [CNT_WIDTH-3:0] divisor,
  output logic                 locked,
  output logic                 done,
  output logic                 error
);

  // state     | meaning
  // IDLE      | detection disabled
  // ARM       | waiting for IDLE_CYCLES of continuous line-high
  // WAIT_EDGE | armed, waiting for the start-bit falling edge
  // MEASURE   | timing the span up to the fifth falling edge
  // LOCKED    | divisor valid, line ignored until enable drops
  typedef enum logic [2:0] {IDLE, ARM, WAIT_EDGE, MEASURE, LOCKED} state_t;

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_WIDTH:0] MIN_COUNT = (CNT_WIDTH+1)'(8 * MIN_PERIOD);

  state_t               state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 fall;
  logic [IW-1:0]        idle_cnt;
  logic [CNT_WIDTH-1:0] span;
  logic [2:0]           edge_cnt;
  logic [CNT_WIDTH:0]   pos;
  logic [CNT_WIDTH:0]   rounded;
  logic                 check_fail;

  assign fall = rx_prev & ~rx_s2;
  // span is cleared on the first edge, so the current offset from that edge is span+1
  assign pos     = {1'b0, span} + (CNT_WIDTH+1)'(1);
  assign rounded = pos + (CNT_WIDTH+1)'(4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

`ifdef AUTOBAUD_CHECK_EN
  logic [CNT_WIDTH:0] last_pos, t0, interval, lo, hi;
  logic               bad, interval_bad;

  assign interval     = pos - last_pos;
  assign lo           = t0 - (t0 >> 3);
  assign hi           = t0 + (t0 >> 3);
  assign interval_bad = (edge_cnt != 3'd0) && ((interval < lo) || (interval > hi));
  assign check_fail   = bad | interval_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_pos <= '0;
      t0       <= '0;
      bad      <= 1'b0;
    end else if (state == WAIT_EDGE && fall) begin
      last_pos <= '0;
      bad      <= 1'b0;
    end else if (state == MEASURE && fall) begin
      last_pos <= pos;
      if (edge_cnt == 3'd0) t0 <= interval;
      bad <= interval_bad | bad;
    end
  end
`else
  assign check_fail = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
      span     <= '0;
      edge_cnt <= '0;
      divisor  <= '0;
      locked   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            idle_cnt <= '0;
            state    <= ARM;
          end
          ARM: begin
            if (!rx_s2) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
              idle_cnt <= '0;
              state    <= WAIT_EDGE;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
          WAIT_EDGE: begin
            if (fall) begin
              span     <= '0;
              edge_cnt <= '0;
              state    <= MEASURE;
            end
          end
          MEASURE: begin
            span <= span + CNT_WIDTH'(1);
            if (fall) begin
              edge_cnt <= edge_cnt + 3'd1;
              if (edge_cnt == 3'd3) begin
                if (pos < MIN_COUNT || check_fail) begin
                  error    <= 1'b1;
                  idle_cnt <= '0;
                  state    <= ARM;
                end else begin
                  divisor <= rounded[CNT_WIDTH:3];
                  locked  <= 1'b1;
                  done    <= 1'b1;
                  state   <= LOCKED;
                end
              end
            end else if (&span) begin
              error    <= 1'b1;
              idle_cnt <= '0;
              state    <= ARM;
            end
          end
          LOCKED: state <= LOCKED;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_autobaud_detector.sv
// Bench for autobaud_detector: directed and randomized 0x55 frames against an edge-interval model.
module tb_autobaud_detector;
  localparam int CW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          rx = 1'b1;
  logic [CW-3:0] divisor;
  logic          locked, done, error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0, err_n = 0, done_cyc = 0, err_cyc = 0;
  int ivs[4];
  int exp_div = 0;
  bit exp_locked = 0;

  autobaud_detector #(.CNT_WIDTH(CW), .IDLE_CYCLES(64), .MIN_PERIOD(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx(rx),
    .divisor(divisor), .locked(locked), .done(done), .error(error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done || error) check("done_error_exclusive", int'(done & error), 0);
    if (done)  begin done_n++; done_cyc = cyc; end
    if (error) begin err_n++;  err_cyc = cyc; end
  end

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // outcome of one frame, from the edge intervals alone: 1 = done, 2 = error
  function automatic int model(output int div);
    int count, t0, lo, hi;
    count = ivs[0] + ivs[1] + ivs[2] + ivs[3];
    div = (count + 4) / 8;
    if (count < 8 * 16) return 2;
`ifdef AUTOBAUD_CHECK_EN
    t0 = ivs[0];
    lo = t0 - t0 / 8;
    hi = t0 + t0 / 8;
    for (int i = 0; i < 4; i++)
      if (ivs[i] < lo || ivs[i] > hi) return 2;
`else
    t0 = 0; lo = 0; hi = 0;
`endif
    return 1;
  endfunction

  task automatic send_frame(output int e5);
    int lo;
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      lo = ivs[i] / 2;
      clk(lo);
      rx = 1'b1;
      clk(ivs[i] - lo);
    end
    rx = 1'b0;
    e5 = cyc;
    clk(ivs[3] / 2);
    rx = 1'b1;
  endtask

  task automatic arm();
    enable = 1'b0;
    clk(2);
    exp_locked = 0;
    enable = 1'b1;
    rx = 1'b1;
    clk(80);
  endtask

  task automatic frame_and_check(input string tag, input bit armed);
    int d0, e0, e5, outcome, div;
    d0 = done_n;
    e0 = err_n;
    outcome = armed ? model(div) : 0;
    send_frame(e5);
    clk(30);
    check({tag, "_done"},  done_n - d0, (outcome == 1) ? 1 : 0);
    check({tag, "_error"}, err_n - e0,  (outcome == 2) ? 1 : 0);
    if (outcome == 1) begin
      exp_div = div;
      exp_locked = 1;
      check({tag, "_done_latency"}, done_cyc - e5, 3);
    end
    if (outcome == 2) check({tag, "_error_latency"}, err_cyc - e5, 3);
    check({tag, "_divisor"}, int'(divisor), exp_div);
    check({tag, "_locked"},  int'(locked), int'(exp_locked));
  endtask

  initial begin
    int c, e0, d0, p, j;
    clk(3);
    check("rst_divisor", int'(divisor), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    reset = 1'b0;
    clk(2);

    arm();
    ivs = '{200, 200, 200, 200};
    frame_and_check("p100", 1);
    ivs = '{120, 120, 120, 120};
    frame_and_check("locked_ignore", 0);

    arm();
    ivs = '{200, 200, 200, 203};
    frame_and_check("round803", 1);
    arm();
    ivs = '{201, 201, 201, 201};
    frame_and_check("round804", 1);

    arm();
    ivs = '{20, 20, 20, 20};
    frame_and_check("glitch", 1);
    rx = 1'b1;
    clk(80);
    ivs = '{100, 100, 100, 100};
    frame_and_check("p50", 1);

    arm();
    ivs = '{200, 300, 200, 200};
    frame_and_check("uneven", 1);

    // timeout: first edge then line held low
    arm();
    e0 = err_n;
    rx = 1'b0;
    c = cyc;
    for (int i = 0; i < 4300 && err_n == e0; i++) clk(1);
    clk(3);
    check("timeout_error", err_n - e0, 1);
    check("timeout_latency", err_cyc - c, 4099);
    check("timeout_locked", int'(locked), 0);
    rx = 1'b1;

    // enable dropped mid-measurement
    arm();
    e0 = err_n;
    d0 = done_n;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) enable = 1'b0;
      rx = 1'b0; clk(100); rx = 1'b1; clk(100);
    end
    rx = 1'b0; clk(100); rx = 1'b1;
    clk(30);
    check("abort_done", done_n - d0, 0);
    check("abort_error", err_n - e0, 0);
    check("abort_locked", int'(locked), 0);
    check("abort_divisor", int'(divisor), exp_div);

    // reset in the middle of a measurement
    arm();
    rx = 1'b0; clk(100); rx = 1'b1; clk(100); rx = 1'b0; clk(20);
    reset = 1'b1;
    clk(2);
    check("midrst_divisor", int'(divisor), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_error", int'(error), 0);
    reset = 1'b0;
    exp_div = 0;
    exp_locked = 0;
    clk(5);
    ivs = '{100, 100, 100, 100};
    frame_and_check("post_rst_unarmed", 0);
    rx = 1'b1;
    clk(80);
    frame_and_check("post_rst", 1);

    for (int n = 0; n < 12; n++) begin
      arm();
      p = $urandom_range(250, 8);
      for (int i = 0; i < 4; i++) begin
        j = int'($urandom_range(p / 2, 0)) - p / 4;
        ivs[i] = 2 * p + j;
      end
      frame_and_check($sformatf("rand%0d", n), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/autobaud_detector.md
Name: autobaud_detector

Overview:
- Receive-side counterpart to the baud rate generator: measures the bit period of an incoming UART line instead of producing one.
- Locks on a sync character 0x55 (8N1, LSB first) and reports the clocks-per-bit divisor.
- Sits between the rx pin and the UART receiver/baud generator so the divisor can be programmed at run time.

Parameters:
- CNT_WIDTH, 20, width of measurement counter; divisor output is CNT_WIDTH-2 bits.
- IDLE_CYCLES, 64, consecutive rx-high cycles required before arming for a start edge.
- MIN_PERIOD, 16, minimum accepted clocks per bit; shorter measurements flagged as error.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  level; high = detection active, low = abort and clear lock
- rx  input  1  asynchronous serial line, idle high
- divisor  output  CNT_WIDTH-2  measured clocks per bit, rounded
- locked  output  1  high while divisor holds a valid measurement
- done  output  1  one-cycle pulse on successful measurement
- error  output  1  one-cycle pulse on rejected measurement

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock.
- Reset values: divisor=0, locked=0, done=0, error=0, state=IDLE, all counters 0, synchronizer flops = 1.
- rx passes through a 2-flop synchronizer. Falling edge = previous synced value 1 and current synced value 0.
- 0x55 frame = 10 alternating bits starting low: falling edges at bit times 0,2,4,6,8. The span from first to fifth falling edge = 8 bit times.
- States:
  - IDLE: enable low. Outputs done and error held 0. On enable=1 -> ARM.
  - ARM: count consecutive synced rx=1 cycles; rx=0 clears the count. Count reaching IDLE_CYCLES -> WAIT_EDGE.
  - WAIT_EDGE: on first falling edge -> MEASURE. Clear span counter; edge_cnt=0.
  - MEASURE:
    - Span counter increments every cycle.
    - Each falling edge increments edge_cnt. The 4th edge after the first (5th overall) ends the measurement.
    - count = cycle index of 5th edge minus cycle index of 1st edge.
  - LOCKED: locked=1, divisor held. Stays here until enable=0.
- Result evaluation, in the cycle after the 5th edge:
  - divisor = (count + 4) >> 3, with the add done at CNT_WIDTH+1 bits (round half up).
  - Success: done pulses 1 cycle, locked rises the same cycle, -> LOCKED.
- Error cases: error pulses 1 cycle in the cycle after detection, -> ARM. divisor and locked are unchanged (locked stays 0).
  - Span counter reaches all-ones before the 5th edge (timeout). Error asserts the cycle after saturation.
  - count < 8*MIN_PERIOD.
- enable=0 in any state: next cycle state=IDLE, locked=0, no done/error pulse, divisor retains its last value.
- done and error are never asserted in the same cycle.
- Synchronizer latency is identical on every edge and does not affect count.
- Reset mid-measurement: immediate return to reset values.

Optional Feature:
- Macro AUTOBAUD_CHECK_EN.
- Defined:
  - Record T0 = cycles between edges 1 and 2.
  - Each of the four edge-to-edge intervals must lie within [T0 - (T0>>3), T0 + (T0>>3)] inclusive.
  - Any violation -> error pulse and -> ARM, evaluated at the 5th edge.
- Not defined: no interval registers, no check; only the timeout and MIN_PERIOD checks apply.

Test Plan:
- Reset asserted mid-operation -> divisor=0, locked=0, done=0, error=0 while reset is high. After release, FSM needs enable plus IDLE_CYCLES of rx high before a measurement is accepted.
- enable=1, rx high 100 cycles, then 0x55 at 100 clocks/bit -> count=800, divisor=100, single done pulse, locked=1; further rx activity ignored.
- Rounding:
  - Edge spans totalling 803 cycles -> divisor=100.
  - 804 cycles -> divisor=101.
- Glitch frame at 10 clocks/bit (count=80 < 128) -> error pulse, locked=0. A following valid 0x55 at 50 clocks/bit -> divisor=50 and done.
- Bench with CNT_WIDTH=12: first falling edge, then rx held low -> error pulse one cycle after span counter hits 4095. enable dropped mid-measure on a second attempt -> no done/error, state IDLE.
- Frame with intervals 200,300,200,200 (count=900):
  - AUTOBAUD_CHECK_EN defined -> error pulse.
  - Undefined -> done, divisor=113.
